// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM encodings and
// operand-signedness helpers also used by the decoder and the execute-stage result mux.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    function automatic logic op1_signed(input logic [2:0] f3);
        return !(f3 == MD_MULHU || f3 == MD_DIVU || f3 == MD_REMU);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return f3 == MD_MUL || f3 == MD_MULH || f3 == MD_DIV || f3 == MD_REM;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath of the multiply/divide unit: 64-bit accumulator, one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, and the final sign fix / select.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      op_i,
    input  logic            neg_i,
    input  logic            special_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic [XLEN-1:0] preload_i,
    output logic [XLEN-1:0] res_o
);

    logic [63:0]     acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;

    logic [32:0]     mul_sum;
    logic [32:0]     rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] rem_next;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] quo, rem;

    // Multiply: product bits shift down into the low half while the multiplier drains out of opb.
    assign mul_sum = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);

    // Divide: dividend MSBs shift out of opa into the remainder, quotient bits into the low half.
    assign rem_sh   = {acc_q[63:32], opa_q[31]};
    assign div_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_next = div_ge ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];

    always_comb begin
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        if (load_i) begin
            acc_d = {32'h0, preload_i};
            opa_d = opa_i;
            opb_d = opb_i;
        end else if (step_i) begin
            if (op_i[2]) begin
                acc_d = {rem_next, acc_q[30:0], div_ge};
                opa_d = opa_q << 1;
            end else begin
                acc_d = {mul_sum, acc_q[31:1]};
                opb_d = opb_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    assign prod_fix = neg_i ? -acc_q : acc_q;
    assign quo      = acc_q[31:0];
    assign rem      = acc_q[63:32];

    always_comb begin
        res_o = acc_q[31:0];
        if (!special_i) begin
            if (!op_i[2]) begin
                res_o = (op_i == MD_MUL) ? prod_fix[31:0] : prod_fix[63:32];
            end else if (!op_i[1]) begin
                res_o = neg_i ? -quo : quo;
            end else begin
                res_o = neg_i ? -rem : rem;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, special-case detection,
// and the stall/valid handshake with the execute stage.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    input  logic            flush,
    output logic            stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept, step;
    logic            s1, s2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, preload, core_res;

    assign accept = (state_q == StIdle) && start && !flush;

    assign s1   = op1_signed(funct3) & opr1[31];
    assign s2   = op2_signed(funct3) & opr2[31];
    assign mag1 = s1 ? -opr1 : opr1;
    assign mag2 = s2 ? -opr2 : opr2;

    assign div_zero = funct3[2] && (opr2 == '0);
    assign div_ovf  = (funct3 == MD_DIV || funct3 == MD_REM)
                      && (opr1 == 32'h8000_0000) && (opr2 == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;

    // Special-case results ride in the accumulator low word and bypass the sign fix.
    always_comb begin
        preload = '0;
        if (div_zero) begin
            preload = funct3[1] ? opr1 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            preload = funct3[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        result_d  = result_q;
        step      = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = funct3;
                    neg_d     = (funct3[2] && funct3[1]) ? s1 : (s1 ^ s2);
                    special_d = special;
                    cnt_d     = '0;
                    state_d   = special ? StDone : StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush) begin
                    result_d = core_res;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

    muldiv_core u_core (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (accept),
        .step_i    (step),
        .op_i      (op_q),
        .neg_i     (neg_q),
        .special_i (special_q),
        .opa_i     (mag1),
        .opb_i     (mag2),
        .preload_i (preload),
        .res_o     (core_res)
    );

    assign stall  = accept || (state_q == StRun);
    assign valid  = (state_q == StDone) && !flush;
    assign result = valid ? core_res : result_q;

endmodule
